// File: rtl/ps_stage_pkg.sv
// ps_stage_pkg: field widths, packet/instruction layouts and output FIFO depth for the PS stage
package ps_stage_pkg;
  localparam int DEST_W = 8;
  localparam int DATA_W = 16;
  localparam int CG_W = 4;
  localparam int OP_W = 6;
  localparam int FIFO_DEPTH = 3;
  typedef struct packed {
    logic [CG_W-1:0] cg;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } pkt_in_t;
  typedef struct packed {
    logic [CG_W-1:0] cg;
    logic [DEST_W-1:0] next_dest;
    logic [OP_W-1:0] opcode;
    logic cpy;
    logic [DATA_W-1:0] data;
  } pkt_out_t;
  typedef struct packed {
    logic v;
    logic [OP_W-1:0] opcode;
    logic [DEST_W-1:0] next_dest;
    logic cpy;
  } inst_t;
endpackage

// File: rtl/ps_stage_if.sv
// ps_stage_if: PS stage bus (upstream handshake, downstream handshake, program-load port, error flag)
interface ps_stage_if import ps_stage_pkg::*; ();
  logic Send_in, Ack_out, Send_out, Ack_in, PS_WE, ERR_out;
  pkt_in_t PACKET_IN;
  pkt_out_t PACKET_OUT;
  logic [DEST_W-1:0] PS_WADDR;
  inst_t PS_WDATA;
  modport master (output Send_in, PACKET_IN, Ack_in, PS_WE, PS_WADDR, PS_WDATA,
                  input Ack_out, Send_out, PACKET_OUT, ERR_out);
  modport slave (input Send_in, PACKET_IN, Ack_in, PS_WE, PS_WADDR, PS_WDATA,
                 output Ack_out, Send_out, PACKET_OUT, ERR_out);
endinterface

// File: rtl/ps_out_fifo.sv
// ps_out_fifo: W-bit, DEPTH-entry FIFO (clk, async rst, push/din, pop, dout = head, count)
module ps_out_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 3,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d = pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end
  assign dout = mem[rd_q];
  assign count = count_q;
endmodule

// File: rtl/ps_stage.sv
// ps_stage: program-storage stage (CLK, async MR, bus slave: accept token, read instruction, queue output)
module ps_stage import ps_stage_pkg::*; (
  input logic CLK,
  input logic MR,
  ps_stage_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  inst_t mem [2**DEST_W];
  inst_t rd_word;
  logic inflight_q, inflight_d, err_q, err_d, accept, push, pop;
  logic [CG_W-1:0] cg_q, cg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CW-1:0] count;
  pkt_out_t push_pkt, head;
  assign bus.Ack_out = !MR && (int'(count) + int'(inflight_q) < FIFO_DEPTH);
  assign bus.Send_out = count != '0;
  assign bus.PACKET_OUT = bus.Send_out ? head : '0;
  assign bus.ERR_out = err_q;
  always_comb begin
    accept = bus.Send_in & bus.Ack_out;
    pop = bus.Send_out & bus.Ack_in;
    push = inflight_q & rd_word.v;
    inflight_d = accept;
    cg_d = accept ? bus.PACKET_IN.cg : cg_q;
    data_d = accept ? bus.PACKET_IN.data : data_q;
    err_d = err_q | (inflight_q & !rd_word.v);
    push_pkt = '{cg: cg_q, next_dest: rd_word.next_dest, opcode: rd_word.opcode,
                 cpy: rd_word.cpy, data: data_q};
  end
  always_ff @(posedge CLK or posedge MR) begin
    if (MR) begin
      inflight_q <= 1'b0;
      err_q <= 1'b0;
      cg_q <= '0;
      data_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q <= err_d;
      cg_q <= cg_d;
      data_q <= data_d;
    end
  end
  // Both assignments are non-blocking, so a same-edge write to the read address returns the old word.
  always_ff @(posedge CLK) begin
    if (bus.PS_WE) mem[bus.PS_WADDR] <= bus.PS_WDATA;
    if (accept) rd_word <= mem[bus.PACKET_IN.dest];
  end
  ps_out_fifo #(.W($bits(pkt_out_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK),
    .rst(MR),
    .push(push),
    .din(push_pkt),
    .pop(pop),
    .dout(head),
    .count(count)
  );
endmodule
